reg_file_scan_ctrl: RTL and testbench

REG_FILE_SCAN_CTRL -- requirements
Module: reg_file_scan_ctrl

---
 rtl/reg_file_scan_ctrl_pkg.sv | 20 ++
 rtl/scan_shift_reg.sv | 40 ++++
 rtl/reg_file_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_reg_file_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_scan_ctrl_pkg.sv
// rtl/reg_file_scan_ctrl_pkg.sv - shared word length, scan FSM state codes and helpers
package reg_file_scan_ctrl_pkg;

  localparam int WORD_LENGTH = 32;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADDR      = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA_IN   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_GNT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACCESS    = 3'd4;
  localparam logic [STATE_W-1:0] ST_SHIFT_OUT = 3'd5;

  // The core's register-file port is claimed while waiting for and during the access.
  function automatic logic state_owns_port(input logic [STATE_W-1:0] s);
    return (s == ST_WAIT_GNT) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// rtl/scan_shift_reg.sv - parallel-load, serial-in/serial-out shift register (MSB first)
module scan_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Parallel load wins over shifting; shifting moves toward the MSB and fills the LSB.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = WIDTH'({data_q, shift_in});
    end
  end

  // Register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;
  assign msb  = data_q[WIDTH-1];

endmodule

// File: rtl/reg_file_scan_ctrl.sv
// rtl/reg_file_scan_ctrl.sv - serial scan access controller for a register file
module reg_file_scan_ctrl
  import reg_file_scan_ctrl_pkg::*;
#(
  parameter  int SIZE   = 16,
  parameter  int WIDTH  = WORD_LENGTH,
  localparam int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sEnable,
  input  logic              sIn,
  output logic              sOut,
  output logic              sBusy,
  output logic              sDone,
  output logic              scanReq,
  input  logic              scanGnt,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [WIDTH-1:0]  regReadData,
  output logic              regWriteEnable,
  output logic [WIDTH-1:0]  regWriteData
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cmd_q, cmd_d;
  logic               sdone_q, sdone_d;

  logic               sr_load;
  logic               sr_shift;
  logic               sr_in;
  logic [WIDTH-1:0]   sr_data;
  logic               sr_msb;

  scan_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data (regReadData),
    .shift_en  (sr_shift),
    .shift_in  (sr_in),
    .data      (sr_data),
    .msb       (sr_msb)
  );

  // Frame sequencing: every state change also clears the bit counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    sdone_d  = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_in    = sIn;
    case (state_q)
      ST_IDLE: begin
        if (sEnable) begin
          cmd_d   = sIn;
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        if (!sEnable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          addr_d = ADDR_W'({addr_q, sIn});
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            state_d = cmd_q ? ST_DATA_IN : ST_WAIT_GNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA_IN: begin
        if (!sEnable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          sr_shift = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_WAIT_GNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_GNT: begin
        if (scanGnt) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        cnt_d = '0;
        if (cmd_q) begin
          state_d = ST_IDLE;
          sdone_d = 1'b1;
        end else begin
          sr_load = 1'b1;
          state_d = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (sEnable) begin
          sr_shift = 1'b1;
          sr_in    = 1'b0;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sdone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state with synchronous active-low reset that abandons any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      sdone_q <= sdone_d;
    end
  end

  // Address 0 is read-only: the frame completes but no write strobe is issued.
  assign regWriteEnable = (state_q == ST_ACCESS) && cmd_q && (addr_q != '0);
  assign regAddr        = addr_q;
  assign regWriteData   = sr_data;
  assign scanReq        = state_owns_port(state_q);
  assign sBusy          = (state_q != ST_IDLE);
  assign sDone          = sdone_q;
  assign sOut           = (state_q == ST_SHIFT_OUT) && sr_msb;

endmodule

// File: tb/tb_reg_file_scan_ctrl.sv
// tb/tb_reg_file_scan_ctrl.sv - self-checking bench for reg_file_scan_ctrl
module tb_reg_file_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sEnable;
  logic        sIn;
  logic        sOut;
  logic        sBusy;
  logic        sDone;
  logic        scanReq;
  logic        scanGnt;
  logic [3:0]  regAddr;
  logic [31:0] rf_rdata;
  logic        regWriteEnable;
  logic [31:0] regWriteData;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int done_cycle = -1;
  int done_count = 0;
  int we_count = 0;

  logic        chk_on = 1'b0;
  logic        exp_busy, exp_req, exp_we, exp_sout, exp_done, exp_zero;
  logic [3:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic        cap_en = 1'b0;
  logic [31:0] rx_word = '0;

  reg_file_scan_ctrl #(
    .SIZE  (16),
    .WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sEnable        (sEnable),
    .sIn            (sIn),
    .sOut           (sOut),
    .sBusy          (sBusy),
    .sDone          (sDone),
    .scanReq        (scanReq),
    .scanGnt        (scanGnt),
    .regAddr        (regAddr),
    .regReadData    (rf_rdata),
    .regWriteEnable (regWriteEnable),
    .regWriteData   (regWriteData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // Per-cycle comparison against the timeline expectations set by the driver.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sBusy", 32'(sBusy), 32'(exp_busy));
      chk("scanReq", 32'(scanReq), 32'(exp_req));
      chk("regWriteEnable", 32'(regWriteEnable), 32'(exp_we));
      chk("sOut", 32'(sOut), 32'(exp_sout));
      chk("sDone", 32'(sDone), 32'(exp_done));
      if (exp_zero) begin
        chk("regAddr_zero", 32'(regAddr), 32'h0);
        chk("regWriteData_zero", regWriteData, 32'h0);
      end else if (exp_we) begin
        chk("regAddr", 32'(regAddr), 32'(exp_addr));
        chk("regWriteData", regWriteData, exp_wdata);
      end
      if (sDone === 1'b1) begin
        done_cycle = cyc_cnt;
        done_count++;
      end
      if (regWriteEnable === 1'b1) we_count++;
      if (cap_en && sEnable) rx_word = {rx_word[30:0], sOut};
    end
  end

  task automatic cyc(input logic en, input logic din, input logic gnt, input logic rstn,
                     input logic e_busy, input logic e_req, input logic e_we,
                     input logic e_sout, input logic e_done, input logic e_zero);
    sEnable  = en;
    sIn      = din;
    scanGnt  = gnt;
    rst      = rstn;
    exp_busy = e_busy;
    exp_req  = e_req;
    exp_we   = e_we;
    exp_sout = e_sout;
    exp_done = e_done;
    exp_zero = e_zero;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
  endtask

  // Sends the first n bits of a write frame; if rst_at hits, reset is pulsed in that cycle.
  task automatic write_bits(input logic [3:0] a, input logic [31:0] d, input int n,
                            input int rst_at, output int start);
    logic [36:0] bits;
    bits      = {1'b1, a, d};
    exp_addr  = a;
    exp_wdata = d;
    start     = cyc_cnt;
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        cyc(1'b1, bits[36-k], 1'b0, 1'b0, k != 0, 0, 0, 0, 0, 0);
        return;
      end
      cyc(1'b1, bits[36-k], 1'b0, 1'b1, k != 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic write_frame(input logic [3:0] a, input logic [31:0] d, input int gwait,
                             output int start);
    write_bits(a, d, 37, -1, start);
    for (int k = 0; k < gwait; k++) cyc(k[0], ~k[0], 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, a != 4'd0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0);
    idle(1);
  endtask

  task automatic read_frame(input logic [3:0] a, input logic [31:0] rd, input int pause_at);
    logic [4:0] bits;
    bits     = {1'b0, a};
    rf_rdata = rd;
    for (int k = 0; k < 5; k++) cyc(1'b1, bits[4-k], 1'b0, 1'b1, k != 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 0, 0, 0);
    cap_en  = 1'b1;
    rx_word = '0;
    for (int i = 0; i < 32; i++) begin
      if (i == pause_at) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, rd[31-i], 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, rd[31-i], 0, 0);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, rd[31-i], 0, 0);
    end
    cap_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0);
    idle(1);
  endtask

  initial begin
    int start;
    int we0;
    int dn0;
    rst      = 1'b0;
    sEnable  = 1'b0;
    sIn      = 1'b0;
    scanGnt  = 1'b0;
    rf_rdata = '0;
    exp_addr = '0;
    exp_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    // Reset state: everything zero, held in reset then released.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Write 0xDEADBEEF to address 5 with immediate grant.
    we0 = we_count;
    write_frame(4'd5, 32'hDEADBEEF, 0, start);
    chk("write_done_latency", 32'(done_cycle - start), 32'd39);
    chk("write_we_pulses", 32'(we_count - we0), 32'd1);

    // Read back 0x12345678 from address 5.
    dn0 = done_count;
    read_frame(4'd5, 32'h12345678, -1);
    chk("read_word", rx_word, 32'h12345678);
    chk("read_first_nibble", 32'(rx_word[31:28]), 32'h1);
    chk("read_done_count", 32'(done_count - dn0), 32'd1);

    // Read with a two-cycle pause in the middle of the shift-out.
    read_frame(4'd10, 32'hA5C30F81, 13);
    chk("read_pause_word", rx_word, 32'hA5C30F81);

    // Abort after two address bits.
    we0 = we_count;
    dn0 = done_count;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    idle(5);
    chk("abort_no_done", 32'(done_count - dn0), 32'd0);
    chk("abort_no_write", 32'(we_count - we0), 32'd0);

    // Grant held off for 10 cycles.
    we0 = we_count;
    write_frame(4'd12, 32'h0BADF00D, 10, start);
    chk("gnt_wait_done_latency", 32'(done_cycle - start), 32'd49);
    chk("gnt_wait_we_pulses", 32'(we_count - we0), 32'd1);

    // Write to address 0 completes without a strobe.
    we0 = we_count;
    dn0 = done_count;
    write_frame(4'd0, 32'h55AA55AA, 0, start);
    chk("addr0_done", 32'(done_count - dn0), 32'd1);
    chk("addr0_no_write", 32'(we_count - we0), 32'd0);

    // Reset during data bit 12, then a full write succeeds.
    we0 = we_count;
    dn0 = done_count;
    write_bits(4'd3, 32'h13579BDF, 37, 17, start);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1);
    idle(2);
    chk("rst_mid_no_write", 32'(we_count - we0), 32'd0);
    chk("rst_mid_no_done", 32'(done_count - dn0), 32'd0);
    write_frame(4'd9, 32'hCAFEF00D, 0, start);
    chk("post_rst_done_latency", 32'(done_cycle - start), 32'd39);
    chk("post_rst_we_pulses", 32'(we_count - we0), 32'd1);

    // Reset while waiting for grant drops scanReq on the next cycle.
    we0 = we_count;
    write_bits(4'd7, 32'h89ABCDEF, 37, -1, start);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1);
    idle(3);
    chk("rst_wait_no_write", 32'(we_count - we0), 32'd0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
